pal_and_or_array: RTL and testbench

- Parametrised, run-time programmable AND-OR logic array: N_OUT outputs, each the OR of N_TERM product terms over N_IN inputs.
- Each product term has a per-input care mask and a per-input polarity.
- Term personality is loaded through a valid/ready config port. A sequential clear engine wipes it on request.
- Data path is a 2-stage pipeline. Used in the lab SoC wherever fixed AND-OR glue previously sat, so the logic function can be changed without re-synthesis.

---
 rtl/pal_pkg.sv | 34 +++
 rtl/pal_term_eval.sv | 23 ++
 rtl/pal_and_or_array.sv | 169 ++++++++++++++++
 tb/tb_pal_and_or_array.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pal_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pal_pkg
// Description : Shared types, state encoding and helpers for the programmable
//               AND-OR array.
// Revision    : 1.0 - initial release
// ============================================================================
package pal_pkg;

    // Default array geometry
    localparam int C_N_IN   = 10;
    localparam int C_N_TERM = 2;
    localparam int C_N_OUT  = 2;

    // Controller state encoding
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    // Personality of a single product term at the default input width
    typedef struct packed {
        logic              en;
        logic [C_N_IN-1:0] care;
        logic [C_N_IN-1:0] pol;
    } term_cfg_t;

    // Config address width: enough bits to index every term, never below one
    function automatic int pal_addr_width(input int n_terms);
        int w;
        w = $clog2(n_terms);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pal_term_eval.sv
`default_nettype none
// ============================================================================
// Module      : pal_term_eval
// Description : Combinational evaluation of one product term. An input takes
//               part only when its care bit is set; its polarity bit selects
//               whether it must be 1 (pol=0) or 0 (pol=1).
// Revision    : 1.0 - initial release
// ============================================================================
module pal_term_eval #(
    parameter int N_IN = 10
) (
    input  logic            en,
    input  logic [N_IN-1:0] care,
    input  logic [N_IN-1:0] pol,
    input  logic [N_IN-1:0] in_data,
    output logic            hit
);

    // A disabled term is 0; an enabled term with no care bits is 1
    assign hit = en & (&(~care | (in_data ^ pol)));

endmodule
`default_nettype wire

// File: rtl/pal_and_or_array.sv
`default_nettype none
// ============================================================================
// Module      : pal_and_or_array
// Description : Run-time programmable AND-OR array with a 2-stage data
//               pipeline, a valid/ready personality write port and a
//               sequential clear engine.
// Revision    : 1.0 - initial release
// ============================================================================
module pal_and_or_array
    import pal_pkg::*;
#(
    parameter  int N_IN   = C_N_IN,
    parameter  int N_TERM = C_N_TERM,
    parameter  int N_OUT  = C_N_OUT,
    localparam int AW     = pal_addr_width(N_OUT * N_TERM)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_data,
    output logic             out_valid,
    output logic [N_OUT-1:0] out_data,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [AW-1:0]    cfg_addr,
    input  logic             cfg_en,
    input  logic [N_IN-1:0]  cfg_care,
    input  logic [N_IN-1:0]  cfg_pol,
    output logic             cfg_err,
    input  logic             clr_req,
    output logic             busy
);

    localparam int            c_num_terms = N_OUT * N_TERM;
    localparam logic [AW-1:0] c_last_idx  = AW'(c_num_terms - 1);

    logic [0:0]             r_state;
    logic [AW-1:0]          r_clr_cnt;
    logic [c_num_terms-1:0] w_term_hit;
    logic [c_num_terms-1:0] r_s1_terms;
    logic                   r_s1_valid;
    logic [N_OUT-1:0]       w_or;
    logic                   r_out_valid;
    logic [N_OUT-1:0]       r_out_data;
    logic                   r_cfg_err;
    logic                   w_idle;
    logic                   w_in_hs;
    logic                   w_cfg_hs;
    logic                   w_cfg_bad;

    // Both ports are open only while idle, so ready depends on state alone
    assign w_idle    = (r_state == ST_IDLE);
    assign in_ready  = w_idle;
    assign cfg_ready = w_idle;
    assign busy      = (r_state == ST_CLEAR);
    assign w_in_hs   = in_valid & w_idle;
    assign w_cfg_hs  = cfg_valid & w_idle;
    assign w_cfg_bad = (int'(cfg_addr) >= c_num_terms);

    // Controller: IDLE accepts traffic; CLEAR walks every term index once
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_clr_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clr_req) begin
                        r_state   <= ST_CLEAR;
                        r_clr_cnt <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (r_clr_cnt == c_last_idx) begin
                        r_state <= ST_IDLE;
                    end
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Term storage and evaluation, one slice per term index
    for (genvar t = 0; t < c_num_terms; t++) begin : g_term
        logic            r_en;
        logic [N_IN-1:0] r_care;
        logic [N_IN-1:0] r_pol;
        logic            w_cfg_wr;
        logic            w_clr_wr;

        assign w_cfg_wr = w_cfg_hs & ~w_cfg_bad & (cfg_addr == AW'(t));
        assign w_clr_wr = busy & (r_clr_cnt == AW'(t));

        // Personality register: the clear engine wipes it, config loads it
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_en   <= 1'b0;
                r_care <= '0;
                r_pol  <= '0;
            end else if (w_clr_wr) begin
                r_en   <= 1'b0;
                r_care <= '0;
                r_pol  <= '0;
            end else if (w_cfg_wr) begin
                r_en   <= cfg_en;
                r_care <= cfg_care;
                r_pol  <= cfg_pol;
            end
        end

        pal_term_eval #(
            .N_IN (N_IN)
        ) u_term_eval (
            .en      (r_en),
            .care    (r_care),
            .pol     (r_pol),
            .in_data (in_data),
            .hit     (w_term_hit[t])
        );
    end

    // Each output ORs its own contiguous group of stage-1 term bits
    for (genvar o = 0; o < N_OUT; o++) begin : g_or
        assign w_or[o] = |r_s1_terms[o*N_TERM +: N_TERM];
    end

    // Stage 1: capture term bits on the input handshake
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_s1_valid <= 1'b0;
            r_s1_terms <= '0;
        end else begin
            r_s1_valid <= w_in_hs;
            if (w_in_hs) begin
                r_s1_terms <= w_term_hit;
            end
        end
    end

    // Stage 2: register the OR result; data holds between valid pulses
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_or;
            end
        end
    end

    // Out-of-range config write flagged on the cycle after its handshake
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_cfg_hs & w_cfg_bad;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign cfg_err   = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_pal_and_or_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_pal_and_or_array
// Description : Self-checking bench for pal_and_or_array (default geometry)
//               plus a 3-term instance for out-of-range config addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pal_and_or_array;
    import pal_pkg::*;

    localparam int NI     = 10;
    localparam int NT     = 2;
    localparam int NO     = 2;
    localparam int NTERMS = NO * NT;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, out_valid;
    logic [9:0]  in_data;
    logic [1:0]  out_data;
    logic        cfg_valid, cfg_ready, cfg_en, cfg_err, clr_req, busy;
    logic [1:0]  cfg_addr;
    logic [9:0]  cfg_care, cfg_pol;

    pal_and_or_array dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
        .cfg_en(cfg_en), .cfg_care(cfg_care), .cfg_pol(cfg_pol),
        .cfg_err(cfg_err), .clr_req(clr_req), .busy(busy)
    );

    // Second instance: 3 outputs x 1 term, so address 3 is out of range
    logic        d2_in_valid, d2_in_ready, d2_out_valid;
    logic [9:0]  d2_in_data;
    logic [2:0]  d2_out_data;
    logic        d2_cfg_valid, d2_cfg_ready, d2_cfg_en, d2_cfg_err, d2_clr_req, d2_busy;
    logic [1:0]  d2_cfg_addr;
    logic [9:0]  d2_cfg_care, d2_cfg_pol;

    pal_and_or_array #(.N_IN(10), .N_TERM(1), .N_OUT(3)) dut2 (
        .clk(clk), .resetn(resetn),
        .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_data(d2_in_data),
        .out_valid(d2_out_valid), .out_data(d2_out_data),
        .cfg_valid(d2_cfg_valid), .cfg_ready(d2_cfg_ready), .cfg_addr(d2_cfg_addr),
        .cfg_en(d2_cfg_en), .cfg_care(d2_cfg_care), .cfg_pol(d2_cfg_pol),
        .cfg_err(d2_cfg_err), .clr_req(d2_clr_req), .busy(d2_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    term_cfg_t  m_term [NTERMS];
    int         m_clr_left;
    bit         m_s1_v, m_s2_v, m_err;
    logic [1:0] m_s1_d, m_s2_d;

    function automatic logic [1:0] model_eval(input logic [9:0] x);
        logic [1:0] r;
        term_cfg_t  tc;
        bit         ok;
        r = '0;
        for (int o = 0; o < NO; o++) begin
            for (int k = 0; k < NT; k++) begin
                tc = m_term[o*NT + k];
                ok = tc.en;
                for (int i = 0; i < NI; i++) begin
                    if (tc.care[i] && (x[i] == tc.pol[i])) ok = 1'b0;
                end
                if (ok) r[o] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int t = 0; t < NTERMS; t++) m_term[t] = '0;
        m_clr_left = 0;
        m_s1_v = 0; m_s2_v = 0; m_err = 0;
        m_s1_d = '0; m_s2_d = '0;
    endtask

    // One clock edge: advance the model with the inputs present at the edge,
    // then compare every observable output.
    task automatic tick();
        bit idle, hs_in, hs_cfg;
        @(posedge clk);
        idle   = (m_clr_left == 0);
        hs_in  = in_valid && idle;
        hs_cfg = cfg_valid && idle;
        m_s2_v = m_s1_v;
        if (m_s1_v) m_s2_d = m_s1_d;
        m_s1_v = hs_in;
        if (hs_in) m_s1_d = model_eval(in_data);
        m_err = hs_cfg && (int'(cfg_addr) >= NTERMS);
        if (hs_cfg && (int'(cfg_addr) < NTERMS)) begin
            m_term[cfg_addr].en   = cfg_en;
            m_term[cfg_addr].care = cfg_care;
            m_term[cfg_addr].pol  = cfg_pol;
        end
        if (idle && clr_req) begin
            m_clr_left = NTERMS;
            for (int t = 0; t < NTERMS; t++) m_term[t] = '0;
        end else if (!idle) begin
            m_clr_left--;
        end
        #1;
        check("out_valid", out_valid, m_s2_v);
        check("out_data",  out_data,  m_s2_d);
        check("busy",      busy,      m_clr_left != 0);
        check("in_ready",  in_ready,  m_clr_left == 0);
        check("cfg_ready", cfg_ready, m_clr_left == 0);
        check("cfg_err",   cfg_err,   m_err);
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic en, input logic [9:0] care, input logic [9:0] pol);
        cfg_valid = 1; cfg_addr = a; cfg_en = en; cfg_care = care; cfg_pol = pol;
        tick();
        cfg_valid = 0;
    endtask

    task automatic send(input logic [9:0] d);
        in_valid = 1; in_data = d;
        tick();
        in_valid = 0;
    endtask

    task automatic program_basic();
        cfg_write(2'd0, 1'b1, 10'h007, 10'h000);
        cfg_write(2'd1, 1'b1, 10'h038, 10'h000);
        cfg_write(2'd2, 1'b1, 10'h0C0, 10'h000);
        cfg_write(2'd3, 1'b1, 10'h300, 10'h000);
    endtask

    typedef struct {
        logic [9:0] din;
        logic [1:0] dout;
    } vec_t;
    vec_t vecs [5];

    initial begin
        vecs[0] = '{10'h3FF, 2'b00};
        vecs[1] = '{10'h007, 2'b01};
        vecs[2] = '{10'h0C0, 2'b10};
        vecs[3] = '{10'h0C3, 2'b10};
        vecs[4] = '{10'h005, 2'b00};

        resetn = 0;
        in_valid = 0; in_data = '0; cfg_valid = 0; cfg_addr = '0; cfg_en = 0;
        cfg_care = '0; cfg_pol = '0; clr_req = 0;
        d2_in_valid = 0; d2_in_data = '0; d2_cfg_valid = 0; d2_cfg_addr = '0;
        d2_cfg_en = 0; d2_cfg_care = '0; d2_cfg_pol = '0; d2_clr_req = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_busy",      busy,      0);
        check("rst_cfg_err",   cfg_err,   0);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_in_ready",  in_ready,  1);
        resetn = 1;
        tick();

        // Table-driven vectors: latency 2 from the handshake cycle
        for (int i = 0; i < 5; i++) begin
            if (i == 1) program_basic();
            send(vecs[i].din);
            check("vec_valid_lat1", out_valid, 0);
            tick();
            check("vec_valid", out_valid, 1);
            check("vec_data",  out_data,  vecs[i].dout);
            tick();
        end

        // Inverted polarity on term3, back-to-back samples
        cfg_write(2'd3, 1'b1, 10'h300, 10'h300);
        in_valid = 1; in_data = 10'h000;
        tick();
        in_data = 10'h300;
        tick();
        check("b2b_valid0", out_valid, 1);
        check("b2b_data0",  out_data,  2'b10);
        in_valid = 0;
        tick();
        check("b2b_valid1", out_valid, 1);
        check("b2b_data1",  out_data,  2'b00);
        tick();

        // Out-of-range config address on the 3-term instance
        d2_cfg_valid = 1; d2_cfg_addr = 2'd3; d2_cfg_en = 1; d2_cfg_care = '0; d2_cfg_pol = '0;
        check("d2_cfg_ready", d2_cfg_ready, 1);
        tick();
        d2_cfg_valid = 0;
        check("d2_err_pulse", d2_cfg_err, 1);
        tick();
        check("d2_err_clear", d2_cfg_err, 0);
        d2_in_valid = 1; d2_in_data = 10'h3FF;
        tick();
        d2_in_valid = 0;
        tick();
        check("d2_bad_valid", d2_out_valid, 1);
        check("d2_bad_data",  d2_out_data,  3'b000);
        d2_cfg_valid = 1; d2_cfg_addr = 2'd2;
        tick();
        d2_cfg_valid = 0;
        check("d2_good_noerr", d2_cfg_err, 0);
        d2_in_valid = 1;
        tick();
        d2_in_valid = 0;
        tick();
        check("d2_good_data", d2_out_data, 3'b100);

        // Clear engine: held clr_req is ignored while clearing
        program_basic();
        clr_req = 1;
        tick();
        check("clr_busy0",  busy,      1);
        check("clr_inrdy0", in_ready,  0);
        check("clr_cfgrdy0", cfg_ready, 0);
        for (int k = 1; k < 4; k++) begin
            if (k == 3) clr_req = 0;
            tick();
            check("clr_busy", busy, 1);
        end
        tick();
        check("clr_done", busy, 0);
        send(10'h007);
        tick();
        check("clr_valid", out_valid, 1);
        check("clr_data",  out_data,  2'b00);

        // Reset while clearing, with a sample still in stage 1
        cfg_write(2'd0, 1'b1, 10'h000, 10'h000);
        in_valid = 1; in_data = 10'h155; clr_req = 1;
        tick();
        in_valid = 0; clr_req = 0;
        #2;
        resetn = 0;
        #1;
        model_reset();
        check("mid_rst_busy",  busy,      0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready,  1);
        tick();
        tick();
        resetn = 1;
        tick();
        send(10'h155);
        tick();
        check("post_rst_valid", out_valid, 1);
        check("post_rst_data",  out_data,  2'b00);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_data   = 10'($urandom);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_addr  = 2'($urandom);
            cfg_en    = ($urandom_range(0, 4) != 0);
            cfg_care  = 10'($urandom & $urandom & $urandom);
            cfg_pol   = 10'($urandom);
            clr_req   = ($urandom_range(0, 39) == 0);
            tick();
        end
        in_valid = 0; cfg_valid = 0; clr_req = 0;
        repeat (6) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
